// File: rtl/pergate_accum_am012.sv
// Sumcheck round accumulator: adds NGATES per-gate V(0..2) contributions
// mod F_Q and strobes ready_pulse when the round is complete.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module pergate_accum_am012 #(
  parameter int NGATES = 8
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              en,
  input  logic                              in_valid,
  input  logic [2:0][`F_NBITS-1:0]          in_vals,
  output logic                              busy,
  output logic [$clog2(NGATES+1)-1:0]       count,
  output logic                              ready_pulse,
  output logic                              ready,
  output logic [2:0][`F_NBITS-1:0]          sums
);

  localparam int FW = `F_NBITS;
  localparam int CW = $clog2(NGATES+1);
  localparam logic [FW:0] QX = (FW+1)'(`F_Q);
  localparam logic [CW-1:0] LAST = CW'(NGATES-1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_n;
  logic [2:0][FW-1:0] sums_n;
  logic [CW-1:0] count_n;
  logic ready_n, pulse_n;
  logic take;

  // One conditional subtract suffices since both operands are below F_Q.
  function automatic logic [FW-1:0] mod_add(
    input logic [FW-1:0] a,
    input logic [FW-1:0] b
  );
    logic [FW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QX) s = s - QX;
    return s[FW-1:0];
  endfunction

  assign take = !en && (state == ACCUM) && in_valid;

  always_comb begin
    state_n = state;
    sums_n  = sums;
    count_n = count;
    ready_n = ready;
    pulse_n = 1'b0;
    unique case (1'b1)
      en: begin
        state_n = ACCUM;
        sums_n  = '0;
        count_n = '0;
        ready_n = 1'b0;
      end
      take: begin
        for (int j = 0; j < 3; j++)
          sums_n[j] = mod_add(sums[j], in_vals[j]);
        count_n = count + 1'b1;
        if (count == LAST) begin
          state_n = DONE;
          ready_n = 1'b1;
          pulse_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      sums        <= '0;
      count       <= '0;
      ready       <= 1'b0;
      ready_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      sums        <= sums_n;
      count       <= count_n;
      ready       <= ready_n;
      ready_pulse <= pulse_n;
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_pergate_accum_am012.sv
// Bench for pergate_accum_am012: four instances (NGATES 4,2,3,1) share
// stimulus and are checked every cycle against a sum/count model.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_pergate_accum_am012;

  localparam int FW = `F_NBITS;
  localparam logic [63:0] Q = 64'(`F_Q);
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0][FW-1:0] in_vals = '0;

  logic busy_a [NI];
  logic ready_a [NI];
  logic pulse_a [NI];
  int unsigned cnt_a [NI];
  logic [2:0][FW-1:0] sums_a [NI];

  int ng [NI] = '{4, 2, 3, 1};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 1;
    logic [$clog2(N+1)-1:0] c;
    logic b, r, p;
    logic [2:0][FW-1:0] s;
    pergate_accum_am012 #(.NGATES(N)) u_dut (
      .clk(clk),
      .rstb(rstb),
      .en(en),
      .in_valid(in_valid),
      .in_vals(in_vals),
      .busy(b),
      .count(c),
      .ready_pulse(p),
      .ready(r),
      .sums(s)
    );
    assign busy_a[g]  = b;
    assign ready_a[g] = r;
    assign pulse_a[g] = p;
    assign cnt_a[g]   = 32'(c);
    assign sums_a[g]  = s;
  end

  // Model: a round is open after en, collects ng contributions, then closes.
  logic        m_open  [NI] = '{default: 1'b0};
  logic        m_ready [NI] = '{default: 1'b0};
  logic        m_pulse [NI] = '{default: 1'b0};
  int unsigned m_cnt   [NI] = '{default: 0};
  logic [63:0] m_sum   [NI][3] = '{default: '{default: 64'd0}};

  always @(posedge clk or negedge rstb) begin
    for (int g = 0; g < NI; g++) begin
      if (!rstb) begin
        m_open[g]  <= 1'b0;
        m_ready[g] <= 1'b0;
        m_pulse[g] <= 1'b0;
        m_cnt[g]   <= 0;
        for (int j = 0; j < 3; j++) m_sum[g][j] <= 64'd0;
      end else begin
        m_pulse[g] <= 1'b0;
        if (en) begin
          m_open[g]  <= 1'b1;
          m_ready[g] <= 1'b0;
          m_cnt[g]   <= 0;
          for (int j = 0; j < 3; j++) m_sum[g][j] <= 64'd0;
        end else if (m_open[g] && in_valid) begin
          for (int j = 0; j < 3; j++)
            m_sum[g][j] <= (m_sum[g][j] + 64'(in_vals[j])) % Q;
          m_cnt[g] <= m_cnt[g] + 1;
          if (m_cnt[g] + 1 == ng[g]) begin
            m_open[g]  <= 1'b0;
            m_ready[g] <= 1'b1;
            m_pulse[g] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("i%0d busy", g), 64'(busy_a[g]), 64'(m_open[g]));
      chk($sformatf("i%0d ready", g), 64'(ready_a[g]), 64'(m_ready[g]));
      chk($sformatf("i%0d pulse", g), 64'(pulse_a[g]), 64'(m_pulse[g]));
      chk($sformatf("i%0d count", g), 64'(cnt_a[g]), 64'(m_cnt[g]));
      for (int j = 0; j < 3; j++)
        chk($sformatf("i%0d sums%0d", g, j), 64'(sums_a[g][j]), m_sum[g][j]);
    end
  end

  // Inputs are applied at a negedge and held across one rising edge.
  task automatic step(input logic e, input logic v,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c);
    en = e;
    in_valid = v;
    in_vals[0] = FW'(a);
    in_vals[1] = FW'(b);
    in_vals[2] = FW'(c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit_sums(input string name, input int g,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c);
    chk({name, " s0"}, 64'(sums_a[g][0]), a);
    chk({name, " s1"}, 64'(sums_a[g][1]), b);
    chk({name, " s2"}, 64'(sums_a[g][2]), c);
  endtask

  initial begin
    #1 rstb = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy_a[0]), 64'd0);
    chk("rst ready", 64'(ready_a[0]), 64'd0);
    chk("rst count", 64'(cnt_a[0]), 64'd0);
    lit_sums("rst", 0, 0, 0, 0);
    rstb = 1'b1;

    // Contribution without en after reset must be ignored.
    step(0, 1, 7, 7, 7);
    chk("noen count", 64'(cnt_a[0]), 64'd0);
    lit_sums("noen", 0, 0, 0, 0);

    // Back-to-back round of four.
    step(1, 0, 0, 0, 0);
    chk("en busy", 64'(busy_a[0]), 64'd1);
    repeat (3) step(0, 1, 1, 2, 3);
    chk("b2b pulse early", 64'(pulse_a[0]), 64'd0);
    step(0, 1, 1, 2, 3);
    chk("b2b pulse", 64'(pulse_a[0]), 64'd1);
    chk("b2b count", 64'(cnt_a[0]), 64'd4);
    lit_sums("b2b", 0, 4, 8, 12);
    lit_sums("n1", 3, 1, 2, 3);
    step(0, 1, 9, 9, 9);
    chk("done pulse gone", 64'(pulse_a[0]), 64'd0);
    chk("done ready", 64'(ready_a[0]), 64'd1);
    lit_sums("done ign", 0, 4, 8, 12);

    // Modular wrap on the NGATES=2 instance.
    step(1, 0, 0, 0, 0);
    step(0, 1, Q - 1, Q - 1, 0);
    step(0, 1, 2, 1, 0);
    lit_sums("wrap", 1, 1, 0, 0);
    chk("wrap ready", 64'(ready_a[1]), 64'd1);

    // Gapped valids on the NGATES=3 instance.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1);
    repeat (4) step(0, 0, 5, 5, 5);
    step(0, 1, 2, 2, 2);
    chk("gap pulse early", 64'(pulse_a[2]), 64'd0);
    chk("gap busy", 64'(busy_a[2]), 64'd1);
    step(0, 1, 3, 3, 3);
    chk("gap pulse", 64'(pulse_a[2]), 64'd1);
    lit_sums("gap", 2, 6, 6, 6);

    // Restart: en wins over a simultaneous contribution.
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 5, 5, 5);
    step(1, 1, 9, 9, 9);
    chk("restart count", 64'(cnt_a[0]), 64'd0);
    repeat (4) step(0, 1, 1, 1, 1);
    lit_sums("restart", 0, 4, 4, 4);
    chk("restart ready", 64'(ready_a[0]), 64'd1);

    // Asynchronous reset mid-round.
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 3, 4, 5);
    in_valid = 1'b0;
    #2 rstb = 1'b0;
    #1;
    chk("arst busy", 64'(busy_a[0]), 64'd0);
    chk("arst count", 64'(cnt_a[0]), 64'd0);
    lit_sums("arst", 0, 0, 0, 0);
    @(negedge clk);
    rstb = 1'b1;
    step(0, 1, 6, 6, 6);
    chk("post arst count", 64'(cnt_a[0]), 64'd0);
    chk("post arst ready", 64'(ready_a[0]), 64'd0);

    // Mixed traffic checked only by the model.
    for (int r = 0; r < 6; r++) begin
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++)
        step(0, 1'($urandom_range(0, 1)),
             {$urandom, $urandom} % Q,
             {$urandom, $urandom} % Q,
             {$urandom, $urandom} % Q);
    end
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pergate_accum_am012.md
PERGATE_ACCUM_AM012 -- requirements
Module: pergate_accum_am012

Interface
REQ-001 SHALL have parameter: NGATES, 8, number of per-gate contributions summed per sumcheck round (>= 1).
REQ-002 SHALL use field width `F_NBITS and modulus `F_Q from field_arith_defs.v.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rstb  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: en  input  1  start pulse; clears sums and begins a round.
REQ-006 SHALL have port: in_valid  input  1  one per-gate contribution present this cycle; driven by a per-gate stage's ready_pulse.
REQ-007 SHALL have port: in_vals  input  `F_NBITS x [2:0]  this gate's contributions to V(0), V(1), V(2).
REQ-008 SHALL have port: busy  output  1  high while in ACCUM.
REQ-009 SHALL have port: count  output  $clog2(NGATES+1)  contributions accepted this round.
REQ-010 SHALL have port: ready_pulse  output  1  one-cycle strobe when the round completes.
REQ-011 SHALL have port: ready  output  1  level; high while sums hold a completed round.
REQ-012 SHALL have port: sums  output  `F_NBITS x [2:0]  registered running/final V(0), V(1), V(2).

Function
REQ-013 SHALL implement states IDLE, ACCUM, DONE; state, count, sums, ready, ready_pulse all registered.
REQ-014 SHALL, on en high in any state, next cycle: sums = 0,0,0; count = 0; state = ACCUM; ready = 0; ready_pulse = 0.
REQ-015 SHALL give en priority over in_valid in the same cycle; that cycle's in_vals are discarded.
REQ-016 SHALL, in ACCUM with in_valid high and en low, update each sums[j] <= (sums[j] + in_vals[j]) mod `F_Q and count <= count + 1.
REQ-017 SHALL compute the modular add in `F_NBITS+1 bits: s = a + b; result = s - `F_Q if s >= `F_Q, else s.
REQ-018 SHALL require in_vals[j] < `F_Q; results for out-of-range inputs are unspecified; sums SHALL always be < `F_Q for in-range inputs.
REQ-019 SHALL accept at most one contribution per cycle; back-to-back and gapped in_valid both legal; idle cycles leave state unchanged.
REQ-020 SHALL, when the accepted contribution makes count reach NGATES, move to DONE on that same edge; from that edge ready = 1 and ready_pulse = 1 for exactly one cycle; latency last in_valid -> ready_pulse = 1 cycle.
REQ-021 SHALL ignore in_valid in IDLE and DONE; sums and count unchanged.
REQ-022 SHALL hold sums, count = NGATES, ready = 1 in DONE until en or reset.
REQ-023 SHALL, with NGATES = 1, complete on the first accepted contribution.
REQ-024 SHALL assert busy exactly when state == ACCUM.

Reset
REQ-025 SHALL, on rstb low, immediately force: state IDLE, sums 0, count 0, busy 0, ready 0, ready_pulse 0, including mid-round; the partial round is lost.
REQ-026 SHALL require en after reset release before any contribution is accepted.

Verification
REQ-027 NGATES=4; en; four back-to-back in_vals (1,2,3) -> sums (4,8,12), count 4, ready_pulse one cycle after 4th valid, ready held.
REQ-028 Wrap: NGATES=2; in_vals (`F_Q-1, `F_Q-1, 0) then (2, 1, 0) -> sums (1, 0, 0).
REQ-029 Gapped: NGATES=3; valids at cycles 0, 5, 6 -> ready_pulse only after cycle-6 edge; busy high throughout.
REQ-030 Restart: NGATES=4; en, two contributions (5,5,5), en with in_valid simultaneously, then four (1,1,1) -> sums (4,4,4); the simultaneous sample is discarded.
REQ-031 Reset mid-round: rstb low after two contributions -> all outputs 0 asynchronously; in_valid after release without en -> no change.
REQ-032 Ignore: in_valid in IDLE and in DONE -> sums, count, ready unchanged; no extra ready_pulse.
